prior_decod_skid: RTL and testbench

//  Registered binary-to-one-hot decoder. This is the receive-side partner of prior_encod.
//  - Input: an N-way index plus an enable bit.
//  - Output: the one-hot line y.
//  - Both sides use valid/ready handshakes with a 2-entry skid buffer.

---
 rtl/prior_pkg.sv | 26 ++
 rtl/prior_skid_buf.sv | 95 +++++++++
 rtl/prior_decod_skid.sv | 69 ++++++
 tb/tb_prior_decod_skid.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/prior_pkg.sv
// Shared definitions for the prior_encod / prior_decod family: default sizes,
// skid-buffer state encoding and the index decode helpers.
package prior_pkg;

  localparam int PRIOR_W = 2;
  localparam int PRIOR_N = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  // Output line j of the decode table: set only for an enabled, matching index.
  function automatic logic prior_dec_hit(input logic en, input logic [31:0] idx,
                                         input int unsigned j);
    return en && (idx == j);
  endfunction

  // Error flag of the decode table: an enabled index outside the N lines.
  function automatic logic prior_dec_err(input logic en, input logic [31:0] idx,
                                         input int unsigned n);
    return en && (idx >= n);
  endfunction

endpackage

// File: rtl/prior_skid_buf.sv
// Generic two-entry skid buffer: registered in_ready and outputs, in-order,
// one transfer per cycle in each direction.
module prior_skid_buf
  import prior_pkg::*;
#(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  skid_state_t   r_state;
  skid_state_t   w_state_nxt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [DW-1:0] r_m;
  logic [DW-1:0] r_s;
  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_ld_m_in;
  logic          w_ld_m_s;
  logic          w_ld_s;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_ld_m_in   = 1'b0;
    w_ld_m_s    = 1'b0;
    w_ld_s      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_ld_m_in   = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_ld_m_in = 1'b1;
        end else if (w_in_xfer) begin
          w_ld_s      = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_xfer) begin
          w_ld_m_s    = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Handshake flags are registered from the next state so neither output
  // has a combinational path from the opposite side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_m         <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      if (w_ld_m_in) begin
        r_m <= in_data;
      end else if (w_ld_m_s) begin
        r_m <= r_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld_s) begin
      r_s <= in_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_m;

endmodule

// File: rtl/prior_decod_skid.sv
// Registered binary-to-one-hot decoder with valid/ready skid buffering.
// Optional sticky error flag enabled by defining PRIOR_DEC_STICKY_ERR_EN.
module prior_decod_skid
  import prior_pkg::*;
#(
  parameter int W = PRIOR_W,
  parameter int N = PRIOR_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_en,
  input  logic [W-1:0] in_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         out_err
`ifdef PRIOR_DEC_STICKY_ERR_EN
  ,
  input  logic         clr_err,
  output logic         err_sticky
`endif
);

  logic [N-1:0] w_y;
  logic         w_err;
  logic [N:0]   w_out_pl;

  // Decode ahead of the buffer so only the N+1 bit result is stored.
  for (genvar j = 0; j < N; j++) begin : g_dec
    assign w_y[j] = prior_dec_hit(in_en, 32'(in_idx), j);
  end
  assign w_err = prior_dec_err(in_en, 32'(in_idx), N);

  prior_skid_buf #(
    .DW(N + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({w_err, w_y}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (w_out_pl)
  );

  assign y       = w_out_pl[N-1:0];
  assign out_err = w_out_pl[N];

`ifdef PRIOR_DEC_STICKY_ERR_EN
  logic r_err_sticky;

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sticky <= 1'b0;
    end else if (out_valid && out_ready && out_err) begin
      r_err_sticky <= 1'b1;
    end else if (clr_err) begin
      r_err_sticky <= 1'b0;
    end
  end

  assign err_sticky = r_err_sticky;
`endif

endmodule

// File: tb/tb_prior_decod_skid.sv
// Bench for prior_decod_skid: N=4 and N=3 instances on a shared stimulus.
module tb_prior_decod_skid;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic       in_en;
  logic [1:0] in_idx;
  logic       in_ready4, out_valid4, err4;
  logic [3:0] y4;
  logic       in_ready3, out_valid3, err3;
  logic [2:0] y3;
`ifdef PRIOR_DEC_STICKY_ERR_EN
  logic       clr_err;
  logic       sticky4, sticky3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prior_decod_skid #(.W(2), .N(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_en(in_en), .in_idx(in_idx), .out_valid(out_valid4),
    .out_ready(out_ready), .y(y4), .out_err(err4)
`ifdef PRIOR_DEC_STICKY_ERR_EN
    , .clr_err(clr_err), .err_sticky(sticky4)
`endif
  );

  prior_decod_skid #(.W(2), .N(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_en(in_en), .in_idx(in_idx), .out_valid(out_valid3),
    .out_ready(out_ready), .y(y3), .out_err(err3)
`ifdef PRIOR_DEC_STICKY_ERR_EN
    , .clr_err(clr_err), .err_sticky(sticky3)
`endif
  );

  typedef struct {
    logic       en;
    logic [1:0] idx;
    logic [3:0] ey4;
    logic [2:0] ey3;
    logic       eerr3;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] q4[$];
    logic [3:0] q3[$];
    logic [3:0] m4;
    logic [2:0] m3;
    logic       e3;

    tbl[0] = '{1'b1, 2'd0, 4'b0001, 3'b001, 1'b0};
    tbl[1] = '{1'b1, 2'd1, 4'b0010, 3'b010, 1'b0};
    tbl[2] = '{1'b1, 2'd2, 4'b0100, 3'b100, 1'b0};
    tbl[3] = '{1'b1, 2'd3, 4'b1000, 3'b000, 1'b1};
    tbl[4] = '{1'b0, 2'd1, 4'b0000, 3'b000, 1'b0};
    tbl[5] = '{1'b0, 2'd3, 4'b0000, 3'b000, 1'b0};
    tbl[6] = '{1'b1, 2'd1, 4'b0010, 3'b010, 1'b0};
    tbl[7] = '{1'b1, 2'd3, 4'b1000, 3'b000, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_en = 1'b0; in_idx = 2'd0;
`ifdef PRIOR_DEC_STICKY_ERR_EN
    clr_err = 1'b0;
`endif

    // Reset state and release
    repeat (3) tick();
    chk("rst_out_valid", out_valid4, 0);
    chk("rst_y", y4, 0);
    rst = 1'b0;
    tick();
    chk("rel_in_ready", in_ready4, 1);
    chk("rel_out_valid", out_valid4, 0);
    chk("rel_y", y4, 4'b0000);
    chk("rel_err", err4, 0);

    // Back-to-back table stream, one result per cycle
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_en = tbl[i].en; in_idx = tbl[i].idx;
      tick();
      chk($sformatf("stream%0d_vld4", i), out_valid4, 1);
      chk($sformatf("stream%0d_y4", i), y4, tbl[i].ey4);
      chk($sformatf("stream%0d_err4", i), err4, 0);
      chk($sformatf("stream%0d_y3", i), y3, tbl[i].ey3);
      chk($sformatf("stream%0d_err3", i), err3, tbl[i].eerr3);
      chk($sformatf("stream%0d_rdy", i), in_ready4, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", out_valid4, 0);

`ifdef PRIOR_DEC_STICKY_ERR_EN
    chk("sticky3_set", sticky3, 1);
    chk("sticky4_clear", sticky4, 0);
    tick();
    chk("sticky3_hold", sticky3, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("sticky3_cleared", sticky3, 0);
`endif

    // Backpressure: two accepted, third held off
    out_ready = 1'b0; in_valid = 1'b1; in_en = 1'b1; in_idx = 2'd1;
    tick();
    chk("bp_rdy_after1", in_ready4, 1);
    in_idx = 2'd2;
    tick();
    in_idx = 2'd3;
    chk("bp_full_rdy", in_ready4, 0);
    chk("bp_full_vld", out_valid4, 1);
    chk("bp_full_y", y4, 4'b0010);
    tick();
    tick();
    chk("bp_hold_y", y4, 4'b0010);
    chk("bp_hold_rdy", in_ready4, 0);
    out_ready = 1'b1;
    tick();
    chk("bp_drain1_y", y4, 4'b0100);
    chk("bp_drain1_rdy", in_ready4, 1);
    tick();
    chk("bp_drain2_y", y4, 4'b1000);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", out_valid4, 0);

    // Asynchronous reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_idx = 2'd1;
    tick();
    in_idx = 2'd2;
    tick();
    in_valid = 1'b0;
    chk("rf_full_rdy", in_ready4, 0);
    #2 rst = 1'b1;
    #1;
    chk("rf_vld_now", out_valid4, 0);
    chk("rf_y_now", y4, 4'b0000);
    chk("rf_rdy_now", in_ready4, 1);
    tick();
    rst = 1'b0;
    tick();
    chk("rf_rel_rdy", in_ready4, 1);
    chk("rf_rel_vld", out_valid4, 0);
    out_ready = 1'b1;
    tick();
    tick();
    chk("rf_no_ghost", out_valid4, 0);

    // Random traffic against scoreboards
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_en     = ($urandom_range(0, 3) != 0);
      in_idx    = 2'($urandom_range(0, 3));
      if (out_valid4 && out_ready) begin
        if (q4.size() == 0) chk("rnd_q4_underflow", 1, 0);
        else chk("rnd_res4", {err4, y4}, q4.pop_front());
      end
      if (out_valid3 && out_ready) begin
        if (q3.size() == 0) chk("rnd_q3_underflow", 1, 0);
        else chk("rnd_res3", {err3, y3}, q3.pop_front());
      end
      m4 = in_en ? (4'b0001 << in_idx) : 4'b0000;
      m3 = (in_en && in_idx < 2'd3) ? (3'b001 << in_idx) : 3'b000;
      e3 = in_en && (in_idx == 2'd3);
      if (in_valid && in_ready4) q4.push_back({1'b0, m4});
      if (in_valid && in_ready3) q3.push_back({e3, m3});
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (out_valid4) begin
        if (q4.size() == 0) chk("drain_q4_underflow", 1, 0);
        else chk("drain_res4", {err4, y4}, q4.pop_front());
      end
      if (out_valid3) begin
        if (q3.size() == 0) chk("drain_q3_underflow", 1, 0);
        else chk("drain_res3", {err3, y3}, q3.pop_front());
      end
      tick();
    end
    chk("rnd_q4_left", q4.size(), 0);
    chk("rnd_q3_left", q3.size(), 0);
    chk("rnd_end_vld", out_valid4, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
